// File: rtl/uart_reply_tx.sv
// Serialises a fixed reply string as back-to-back 8N1 frames on each send
// request, holding at most one queued request while a reply is in flight.
module uart_reply_tx #(
  parameter int                   MSG_LEN = 6,
  parameter logic [8*MSG_LEN-1:0] MSG     = {"P", "O", "L", "O", 8'h0D, 8'h0A}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       dropped,
  output logic [2:0] state_dbg
);

  localparam int BW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state, state_n;
  logic [BW-1:0]   byte_idx, byte_n;
  logic [2:0]      bit_idx, bit_n;
  logic            pending, pending_n;
  logic            done_n, dropped_n, tx_n;
  logic [7:0]      cur_byte;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      bit_idx  <= '0;
      pending  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_n;
      byte_idx <= byte_n;
      bit_idx  <= bit_n;
      pending  <= pending_n;
      tx       <= tx_n;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
      dropped  <= dropped_n;
    end
  end

  always_comb begin
    state_n   = state;
    byte_n    = byte_idx;
    bit_n     = bit_idx;
    pending_n = pending;
    done_n    = 1'b0;
    dropped_n = 1'b0;

    // Request handling first, so a send on the final stop tick is seen as pending.
    if (send) begin
      if (state == S_IDLE) begin
        state_n = S_ARM;
      end else if (!pending) begin
        pending_n = 1'b1;
      end else begin
        dropped_n = 1'b1;
      end
    end

    if (baud_tick) begin
      case (state)
        S_ARM: begin
          state_n = S_START;
          byte_n  = '0;
        end
        S_START: begin
          state_n = S_DATA;
          bit_n   = 3'd0;
        end
        S_DATA: begin
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (byte_idx != LAST_BYTE) begin
            byte_n  = byte_idx + 1'b1;
            state_n = S_START;
          end else begin
            done_n = 1'b1;
            byte_n = '0;
            if (pending_n) begin
              pending_n = 1'b0;
              state_n   = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (byte_n == BW'(k)) cur_byte = MSG[8*(MSG_LEN-k)-1 -: 8];
    end
  end

  // Line level is derived from the state being entered so tx stays registered.
  always_comb begin
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = cur_byte[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_reply_tx.md
# uart_reply_tx

Message-level UART transmitter that sits directly downstream of the pattern comparator. On a one-cycle `send` pulse it serialises a fixed parameterised reply string, "POLO\r\n" by default, as back-to-back 8N1 frames on `tx`. Bit timing comes from the existing bit-rate `baud_tick` generator. It holds one queued request so a match arriving mid-reply is not lost.

## Interface
- `MSG_LEN`, 6: number of bytes in the reply; must be ≥1.
- `MSG`, {"P","O","L","O",8'h0D,8'h0A}: `8*MSG_LEN` bits; byte 0 in the MSBs, sent first.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `baud_tick` input 1: one-cycle strobe at the bit rate; every bit lasts exactly one tick period.
- `send` input 1: one-cycle request to transmit the reply.
- `tx` output 1: serial line, idle high, registered.
- `busy` output 1: high from the cycle after an accepted `send` until the reply (and any queued reply) completes.
- `done` output 1: one-cycle pulse at the end of the last stop bit of each reply.
- `dropped` output 1: one-cycle pulse when a `send` is discarded.

## Operation
- State machine states:
  - IDLE: `tx`=1, `busy`=0.
  - ARM: waiting for tick alignment, `tx`=1.
  - START: `tx`=0.
  - DATA: 8 bits, LSB first.
  - STOP: `tx`=1.
- All transitions out of ARM, START, DATA and STOP occur only in cycles where `baud_tick`=1.
- IDLE → ARM on `send`.
- ARM → START on the next tick.
- START → DATA (bit index 0) on tick.
- DATA advances its bit index on each tick; after bit 7 → STOP.
- STOP on tick:
  - If byte index < `MSG_LEN`-1: increment the byte index, go to START (no inter-byte gap).
  - Otherwise: pulse `done`.
    - If the pending flag is set: clear it, reset the byte index to 0, go to START directly.
    - Else go to IDLE.
- Pending flag, one deep:
  - A `send` while in any state other than IDLE, with pending clear, sets pending.
  - A `send` while pending is already set is discarded; `dropped` pulses in the following cycle.
- Byte selection: byte k = `MSG[8*(MSG_LEN-k)-1 -: 8]`.
- Byte index width: `$clog2(MSG_LEN)` (minimum 1). Bit index: 3 bits.
- One reply = `MSG_LEN`×10 bit periods.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `dropped`=0. State IDLE, indices 0, pending 0.
- Reset is effective at the next edge and overrides everything, including mid-frame: `tx` returns high on that edge and the partial frame is abandoned.
- All outputs are registered. Each output changes on the clock edge that ends the cycle in which its cause was sampled:
  - `send` sampled in cycle n → `busy`=1 from cycle n+1.
  - The first `baud_tick` sampled in cycle m > n → `tx`=0 from cycle m+1.
  - A `baud_tick` coincident with `send` in IDLE does not start the bit; the start bit begins on the next tick.
- `done` and `busy` falling: both occur on the edge after the final STOP tick. In that same edge `tx` stays 1 (idle), or drops to 0 when a pending restart begins.
- `send` coincident with the final STOP tick: treated as pending. The restart happens immediately, `busy` stays high, and `done` still pulses.
- `send` in the same cycle as `rst`: ignored.
- `baud_tick` in IDLE: ignored.

## Test plan
- Single reply, tick every 4 clocks, one `send`:
  - Decode `tx` frames as 0x50, 0x4F, 0x4C, 0x4F, 0x0D, 0x0A.
  - Each bit lasts 4 clocks; the line stays low for the start bit only.
  - `done` pulses exactly once after 60 tick periods; `busy` falls in the same cycle as `done` rises.
- Two `send` pulses 20 clocks apart:
  - Two complete replies back to back with no idle bit between them.
  - `done` pulses twice; `busy` stays high throughout; `dropped` never pulses.
- Three `send` pulses during one reply:
  - Exactly two replies are sent.
  - `dropped` pulses once, one cycle after the third `send`.
- `rst` asserted during bit 3 of byte 2:
  - `tx`=1 and `busy`=0 on the next edge; no `done` pulse.
  - A subsequent `send` produces a full, correct reply starting from byte 0x50.
- `send` in the same cycle as a `baud_tick` while IDLE:
  - Start bit begins after the following tick, not this one.
  - `send` coincident with the final STOP tick yields an immediate second reply, with `done`=1 and `busy` remaining 1.
- `MSG_LEN`=1, `MSG`=8'hA5: one 10-bit frame; `tx` data bits read 1,0,1,0,0,1,0,1 (LSB first); `done` pulses once.
